// File: rtl/regfile_write_decoder.sv
// Write side of the 32-entry register file: buffers write-back requests in a
// 2-entry FIFO and issues them as one-cycle one-hot strobes. Optional build
// macro REGWR_COALESCE_EN merges a request into the newest unissued entry.
module regfile_write_decoder #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_stall,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [DATA_W-1:0]   reg_wdata,
  input  logic [ADDR_W-1:0]   chk_addr,
  output logic                chk_hit,
  output logic                busy
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t          fifo_q [FIFO_DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;

  logic               accept;
  logic               is_zero;
  logic               push;
  logic               pop;
  logic               coalesce;
  wr_entry_t          head;
  logic [NUM_REGS-1:0] head_onehot;
  logic [FIFO_DEPTH-1:0] slot_valid;

  assign wr_ready = !reset && (count < CNT_W'(FIFO_DEPTH));
  assign accept   = wr_valid && wr_ready;
  assign is_zero  = (wr_addr == ADDR_W'(ZERO_REG));
  assign pop      = (count != '0) && !wr_stall;
  assign head     = fifo_q[rd_ptr];

`ifdef REGWR_COALESCE_EN
  logic newest;
  assign newest = ~wr_ptr;
  // An entry being popped this edge is already issuing, so it cannot absorb data.
  assign coalesce = accept && !is_zero && (count != '0)
                    && !(pop && (count == CNT_W'(1)))
                    && (fifo_q[newest].addr == wr_addr);
`else
  assign coalesce = 1'b0;
`endif

  assign push = accept && !is_zero && !coalesce;

  // Occupancy update
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Address decode of the head entry into a one-hot strobe
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      head_onehot[i] = (head.addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
      reg_we    <= '0;
      reg_wdata <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{addr: wr_addr, data: wr_data};
        wr_ptr         <= ~wr_ptr;
      end
`ifdef REGWR_COALESCE_EN
      if (coalesce) begin
        fifo_q[newest].data <= wr_data;
      end
`endif
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        reg_we    <= head_onehot;
        reg_wdata <= head.data;
      end else begin
        reg_we    <= '0;
      end
      count <= count_next;
    end
  end

  // Slot at rd_ptr is live with one entry; the other slot only when full
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      slot_valid[i] = (1'(i) == rd_ptr) ? (count != '0) : (count == CNT_W'(FIFO_DEPTH));
    end
  end

  always_comb begin
    chk_hit = reg_we[chk_addr];
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (slot_valid[i] && (fifo_q[i].addr == chk_addr)) begin
        chk_hit = 1'b1;
      end
    end
    if (chk_addr == ADDR_W'(ZERO_REG)) begin
      chk_hit = 1'b0;
    end
  end

  assign busy = (count != '0) || (reg_we != '0);

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Self-checking bench for regfile_write_decoder: directed scenarios then random
// traffic, compared against a queue-based model of the write-back buffer.
module tb_regfile_write_decoder;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_stall;
  logic [31:0] reg_we;
  logic [63:0] reg_wdata;
  logic [4:0]  chk_addr;
  logic        chk_hit;
  logic        busy;

  regfile_write_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_stall  (wr_stall),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .chk_addr  (chk_addr),
    .chk_hit   (chk_hit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } mentry_t;

  mentry_t     mq[$];
  logic [31:0] exp_we;
  logic [63:0] exp_wdata;
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hit(input logic [4:0] a);
    if (a == 5'd31) return 1'b0;
    foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
    return exp_we[a];
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_we    = '0;
    exp_wdata = '0;
  endtask

  // What the buffer does at the coming rising edge, given the driven inputs
  task automatic model_edge(input logic v, input logic [4:0] a, input logic [63:0] d,
                            input logic s);
    mentry_t h;
    mentry_t e;
    bit      acc;
    acc = v && (mq.size() < 2);
    if (mq.size() > 0 && !s) begin
      h         = mq.pop_front();
      exp_we    = 32'd1 << h.addr;
      exp_wdata = h.data;
    end else begin
      exp_we = '0;
    end
    if (acc && a != 5'd31) begin
`ifdef REGWR_COALESCE_EN
      if (mq.size() > 0 && mq[mq.size()-1].addr == a) begin
        mq[mq.size()-1].data = d;
      end else begin
        e.addr = a; e.data = d; mq.push_back(e);
      end
`else
      e.addr = a; e.data = d; mq.push_back(e);
`endif
    end
  endtask

  task automatic step(input logic v, input logic [4:0] a, input logic [63:0] d,
                      input logic s, input logic [4:0] c);
    @(negedge clk);
    wr_valid = v; wr_addr = a; wr_data = d; wr_stall = s; chk_addr = c;
    #1;
    chk("wr_ready",  wr_ready,  mq.size() < 2);
    chk("busy",      busy,      (mq.size() != 0) || (exp_we != 0));
    chk("reg_we",    reg_we,    exp_we);
    chk("reg_wdata", reg_wdata, exp_wdata);
    chk("chk_hit",   chk_hit,   model_hit(c));
    model_edge(v, a, d, s);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    reset = 1'b1; wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234;
    wr_stall = 1'b0; chk_addr = 5'd5;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_reg_we",   reg_we,   32'h0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_busy",     busy,     1'b0);
    end
    @(negedge clk);
    reset = 1'b0; wr_valid = 1'b0;
    #1;
    chk("post_rst_ready", wr_ready, 1'b1);
    model_edge(1'b0, 5'd0, 64'h0, 1'b0);

    // Single write, minimum latency
    step(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd5);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd5);
    chk("lat_we_n", reg_we, 32'h0);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd5);
    chk("lat_we_n1", reg_we, 32'h0000_0020);
    chk("lat_wd_n1", reg_wdata, 64'hDEAD_BEEF_0000_0001);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd5);
    chk("lat_we_n2", reg_we, 32'h0);

    // Zero register write is swallowed
    step(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd31);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'd0, 64'h0, 1'b0, 5'd31);
      chk("xzr_we",   reg_we,  32'h0);
      chk("xzr_busy", busy,    1'b0);
      chk("xzr_hit",  chk_hit, 1'b0);
    end

    // Back-to-back stream
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 5'(i), 64'h100 + 64'(i), 1'b0, 5'(i));
      chk("b2b_ready", wr_ready, 1'b1);
    end
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    chk("b2b_we3", reg_we, 32'h8);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    chk("b2b_we4", reg_we, 32'h10);
    chk("b2b_wd4", reg_wdata, 64'h104);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);

    // Stall fills the buffer
`ifdef REGWR_COALESCE_EN
    step(1'b1, 5'd9, 64'hAAAA, 1'b1, 5'd9);
    step(1'b1, 5'd9, 64'hBBBB, 1'b1, 5'd9);
    step(1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
    chk("coal_ready", wr_ready, 1'b1);
    chk("coal_hit9",  chk_hit,  1'b1);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd9);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd9);
    chk("coal_we", reg_we, 32'h200);
    chk("coal_wd", reg_wdata, 64'hBBBB);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd9);
    chk("coal_we_after", reg_we, 32'h0);
`else
    step(1'b1, 5'd7, 64'h7777, 1'b1, 5'd7);
    step(1'b1, 5'd9, 64'h9999, 1'b1, 5'd9);
    step(1'b0, 5'd0, 64'h0, 1'b1, 5'd7);
    chk("stall_ready", wr_ready, 1'b0);
    chk("stall_hit7",  chk_hit,  1'b1);
    step(1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
    chk("stall_hit9",  chk_hit,  1'b1);
    step(1'b0, 5'd0, 64'h0, 1'b1, 5'd8);
    chk("stall_hit8",  chk_hit,  1'b0);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd7);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd7);
    chk("drain_we7", reg_we, 32'h80);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd9);
    chk("drain_we9", reg_we, 32'h200);
    chk("drain_wd9", reg_wdata, 64'h9999);
    chk("drain_ready", wr_ready, 1'b1);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
`endif

    // Async reset while one write issues and one is buffered
    step(1'b1, 5'd7, 64'h7070, 1'b1, 5'd7);
    step(1'b1, 5'd9, 64'h9090, 1'b1, 5'd9);
    step(1'b0, 5'd0, 64'h0, 1'b0, 5'd9);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_we",   reg_we,  32'h0);
    chk("arst_busy", busy,    1'b0);
    chk("arst_hit",  chk_hit, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; wr_valid = 1'b0; wr_stall = 1'b0;
    #1;
    chk("arst_ready", wr_ready, 1'b1);
    model_edge(1'b0, 5'd0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'd0, 64'h0, 1'b0, 5'd9);
      chk("arst_quiet", reg_we, 32'h0);
    end

    // Random traffic, addresses biased to a small set to exercise hazards
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a;
      logic [4:0] c;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      c = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      step($urandom_range(0, 3) != 0, a, {32'($urandom), 32'($urandom)},
           $urandom_range(0, 3) == 0, c);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
